stride_transpose_rd: RTL

// - Reader-side counterpart of the 4-lane skewed FIFO write stage in the fft_16 datapath.
// - Accepts one NxN tile as N parallel lanes over N cycles and emits its transpose over N cycles.
// - Ping-pong banks allow back-to-back tiles with no bubbles.
// - Sits between an FFT butterfly column and the next stage that needs stride-N reordered data.

---
 rtl/stride_transpose_rd.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stride_transpose_rd.sv
// N x N tile transposer: rows arrive as N parallel lanes, columns leave as N parallel lanes.
// Two register banks ping-pong so that consecutive tiles stream without bubbles.
module stride_transpose_rd #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int LOG2N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   data_in,
    input  logic                 ctrl_in,
    output logic [N*WIDTH-1:0]   data_out,
    output logic                 ctrl_out,
    output logic                 valid_out,
    output logic [LOG2N-1:0]     addr,
    output logic                 blk_err
);
    localparam logic [LOG2N-1:0] ROW_ZERO = LOG2N'(0);
    localparam logic [LOG2N-1:0] ROW_ONE  = LOG2N'(1);
    localparam logic [LOG2N-1:0] ROW_LAST = LOG2N'(N - 1);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} wr_state_t;
    typedef enum logic {RIDLE = 1'b0, READ = 1'b1} rd_state_t;

    wr_state_t          wr_state_r;
    rd_state_t          rd_state_r;
    logic [LOG2N-1:0]   wr_cnt_r;
    logic [LOG2N-1:0]   rd_cnt_r;
    logic               wr_bank_r;
    logic               rd_bank_r;
    logic [1:0]         full_r;
    logic               abort_r;
    logic [N*WIDTH-1:0] mem_r [2][N];

    logic               wr_en_s;
    logic               wr_last_s;
    logic               abort_s;
    logic [LOG2N-1:0]   wr_row_s;
    logic               rd_go_s;
    logic               rd_last_s;
    logic [1:0]         full_set_s;
    logic [1:0]         full_clr_s;
    logic [N*WIDTH-1:0] col_s;

    // Write-side decode: a start or abort always lands in row 0 of the current bank.
    always_comb begin
        wr_en_s    = 1'b0;
        abort_s    = 1'b0;
        wr_last_s  = 1'b0;
        wr_row_s   = wr_cnt_r;
        case (wr_state_r)
            IDLE: begin
                if (ctrl_in) begin
                    wr_en_s  = 1'b1;
                    wr_row_s = ROW_ZERO;
                end else begin
                    wr_en_s  = 1'b0;
                end
            end
            FILL: begin
                wr_en_s = 1'b1;
                if (ctrl_in) begin
                    abort_s  = 1'b1;
                    wr_row_s = ROW_ZERO;
                end else begin
                    wr_last_s = (wr_cnt_r == ROW_LAST);
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
        full_set_s = wr_last_s ? {wr_bank_r, ~wr_bank_r} : 2'b00;
    end

    // Read-side decode: a full bank is consumed as soon as it is seen, even from RIDLE.
    always_comb begin
        rd_go_s    = (rd_state_r == READ) || full_r[rd_bank_r];
        rd_last_s  = rd_go_s && (rd_cnt_r == ROW_LAST);
        full_clr_s = rd_last_s ? {rd_bank_r, ~rd_bank_r} : 2'b00;
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        assign col_s[j*WIDTH +: WIDTH] = mem_r[rd_bank_r][j][rd_cnt_r*WIDTH +: WIDTH];
    end

    // Tile storage; left unreset because reads are gated by the full flags.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_bank_r][wr_row_s] <= data_in;
        end else begin
            mem_r[wr_bank_r][wr_row_s] <= mem_r[wr_bank_r][wr_row_s];
        end
    end

    // Write FSM, bank-full flags and the delayed abort pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_r <= IDLE;
            wr_cnt_r   <= ROW_ZERO;
            wr_bank_r  <= 1'b0;
            full_r     <= 2'b00;
            abort_r    <= 1'b0;
            blk_err    <= 1'b0;
        end else begin
            full_r  <= (full_r & ~full_clr_s) | full_set_s;
            abort_r <= abort_s;
            blk_err <= abort_r;
            case (wr_state_r)
                IDLE: begin
                    if (ctrl_in) begin
                        wr_cnt_r   <= ROW_ONE;
                        wr_state_r <= FILL;
                    end else begin
                        wr_cnt_r   <= ROW_ZERO;
                        wr_state_r <= IDLE;
                    end
                end
                FILL: begin
                    if (ctrl_in) begin
                        wr_cnt_r   <= ROW_ONE;
                        wr_state_r <= FILL;
                    end else if (wr_last_s) begin
                        wr_cnt_r   <= ROW_ZERO;
                        wr_bank_r  <= ~wr_bank_r;
                        wr_state_r <= IDLE;
                    end else begin
                        wr_cnt_r   <= wr_cnt_r + ROW_ONE;
                        wr_state_r <= FILL;
                    end
                end
                default: begin
                    wr_cnt_r   <= ROW_ZERO;
                    wr_state_r <= IDLE;
                end
            endcase
        end
    end

    // Read FSM with registered outputs; everything is forced to zero outside a tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_r <= RIDLE;
            rd_cnt_r   <= ROW_ZERO;
            rd_bank_r  <= 1'b0;
            valid_out  <= 1'b0;
            ctrl_out   <= 1'b0;
            addr       <= ROW_ZERO;
            data_out   <= '0;
        end else if (rd_go_s) begin
            valid_out <= 1'b1;
            ctrl_out  <= (rd_cnt_r == ROW_ZERO);
            addr      <= rd_cnt_r;
            data_out  <= col_s;
            rd_cnt_r  <= rd_cnt_r + ROW_ONE;
            if (rd_last_s) begin
                rd_bank_r  <= ~rd_bank_r;
                rd_state_r <= full_r[~rd_bank_r] ? READ : RIDLE;
            end else begin
                rd_state_r <= READ;
            end
        end else begin
            rd_state_r <= RIDLE;
            rd_cnt_r   <= ROW_ZERO;
            valid_out  <= 1'b0;
            ctrl_out   <= 1'b0;
            addr       <= ROW_ZERO;
            data_out   <= '0;
        end
    end
endmodule
